// File: rtl/tx_command_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tx_command_sequencer
//
// Sequences the USB transmit path for the AHB-lite slave register block.
// A one-byte command written to the TX control register is checked against
// buffer occupancy, launched with a start strobe, and tracked to completion
// or error. The register block is then told to clear the command. FIFO flush
// sequencing lives here too, so a TX launch and a buffer flush can never
// overlap.
//
// Ports:
//   clk                 system clock, rising edge
//   n_rst               asynchronous reset, active-high (1 = reset)
//   cmd_valid           one-cycle pulse: TX control register written
//   cmd[7:0]            command byte: 1=DATA 2=ACK 3=NAK 4=STALL, else invalid
//   flush_req           one-cycle pulse: flush-buffer register written
//   buffer_occupancy    current FIFO byte count
//   tx_transfer_active  transmitter busy
//   tx_error            transmitter error pulse
//   tx_packet[1:0]      packet type: ACK=0 NAK=1 DATA=2 STALL=3
//   tx_start            one-cycle launch strobe to the transmitter
//   clear               one-cycle FIFO flush strobe
//   busy                high in every state except IDLE
//   done                one-cycle completion pulse
//   cmd_clear           one-cycle pulse to zero TX control, same cycle as done
//   err_code[1:0]       0=OK 1=EMPTY/INVALID 2=TIMEOUT 3=TXERR
//   cmd_overrun         one-cycle pulse: a command or flush request was dropped
// ---------------------------------------------------------------------------
module tx_command_sequencer #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TO_W           = 10
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd,
  input  logic       flush_req,
  input  logic [6:0] buffer_occupancy,
  input  logic       tx_transfer_active,
  input  logic       tx_error,
  output logic [1:0] tx_packet,
  output logic       tx_start,
  output logic       clear,
  output logic       busy,
  output logic       done,
  output logic       cmd_clear,
  output logic [1:0] err_code,
  output logic       cmd_overrun
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    START,
    WAIT_ACTIVE,
    WAIT_DONE,
    FLUSH,
    FLUSH_WAIT,
    REPORT
  } state_t;

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_INVALID = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_TXERR   = 2'd3;

  state_t          state_q, state_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [1:0]      tx_packet_q, tx_packet_d;
  logic [1:0]      err_code_q, err_code_d;
  logic            tx_start_q, tx_start_d;
  logic            clear_q, clear_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            cmd_overrun_q, cmd_overrun_d;

  logic            timed_out;
  logic            cmd_known;
  logic [1:0]      cmd_packet;

  // Command byte to transmitter packet encoding; the two numberings differ.
  always_comb begin
    cmd_known  = 1'b1;
    cmd_packet = 2'd0;
    case (cmd_q)
      8'd1:    cmd_packet = 2'd2;
      8'd2:    cmd_packet = 2'd0;
      8'd3:    cmd_packet = 2'd1;
      8'd4:    cmd_packet = 2'd3;
      default: cmd_known  = 1'b0;
    endcase
  end

  assign timed_out = (cnt_q == TO_MAX);

  // Next-state logic. The counter only advances while below TO_MAX, so it
  // saturates rather than wrapping.
  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    cnt_d         = cnt_q;
    tx_packet_d   = tx_packet_q;
    err_code_d    = err_code_q;
    cmd_overrun_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (flush_req) begin
          // Flush wins a same-cycle collision; the command is dropped.
          state_d       = FLUSH;
          cmd_overrun_d = cmd_valid;
        end else if (cmd_valid) begin
          cmd_d      = cmd;
          err_code_d = ERR_OK;
          state_d    = CHECK;
        end
      end
      CHECK: begin
        if (!cmd_known || (cmd_q == 8'd1 && buffer_occupancy == 7'd0)) begin
          err_code_d = ERR_INVALID;
          state_d    = REPORT;
        end else begin
          tx_packet_d = cmd_packet;
          state_d     = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_ACTIVE;
      end
      WAIT_ACTIVE: begin
        if (tx_transfer_active) begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else if (timed_out) begin
          err_code_d = ERR_TIMEOUT;
          state_d    = REPORT;
        end else if (tx_error) begin
          err_code_d = ERR_TXERR;
          state_d    = REPORT;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      WAIT_DONE: begin
        if (tx_error) begin
          err_code_d = ERR_TXERR;
          state_d    = REPORT;
        end else if (!tx_transfer_active) begin
          state_d = REPORT;
        end
      end
      FLUSH: begin
        cnt_d   = '0;
        state_d = FLUSH_WAIT;
      end
      FLUSH_WAIT: begin
        if (buffer_occupancy == 7'd0) begin
          state_d = IDLE;
        end else if (timed_out) begin
          err_code_d = ERR_TIMEOUT;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      REPORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Any request landing while busy is dropped and flagged next cycle.
    if (state_q != IDLE && (cmd_valid || flush_req)) begin
      cmd_overrun_d = 1'b1;
    end

    if (state_d == IDLE) begin
      tx_packet_d = 2'd0;
    end
  end

  // Strobes and status are decoded from the next state so the registered
  // outputs line up with the state they describe.
  always_comb begin
    tx_start_d = (state_d == START);
    clear_d    = (state_d == FLUSH);
    done_d     = (state_d == REPORT);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_q       <= IDLE;
      cmd_q         <= 8'd0;
      cnt_q         <= '0;
      tx_packet_q   <= 2'd0;
      err_code_q    <= ERR_OK;
      tx_start_q    <= 1'b0;
      clear_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cmd_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      cnt_q         <= cnt_d;
      tx_packet_q   <= tx_packet_d;
      err_code_q    <= err_code_d;
      tx_start_q    <= tx_start_d;
      clear_q       <= clear_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      cmd_overrun_q <= cmd_overrun_d;
    end
  end

  assign tx_packet   = tx_packet_q;
  assign tx_start    = tx_start_q;
  assign clear       = clear_q;
  assign busy        = busy_q;
  assign done        = done_q;
  // cmd_clear shares the done flop so the two can never drift apart.
  assign cmd_clear   = done_q;
  assign err_code    = err_code_q;
  assign cmd_overrun = cmd_overrun_q;

endmodule

// File: tb/tb_tx_command_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_tx_command_sequencer
//
// Self-checking bench for tx_command_sequencer. A table of command records
// is applied back-to-back; each record's expected outcome is queued when the
// command is driven and compared when done pulses. Hand-written sequences
// cover flush collisions, flush timeout, overrun while busy and reset
// mid-transfer.
// ---------------------------------------------------------------------------
module tb_tx_command_sequencer;

  localparam int TIMEOUT = 1023;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       cmd_valid;
  logic [7:0] cmd;
  logic       flush_req;
  logic [6:0] buffer_occupancy;
  logic       tx_transfer_active;
  logic       tx_error;
  logic [1:0] tx_packet;
  logic       tx_start;
  logic       clear;
  logic       busy;
  logic       done;
  logic       cmd_clear;
  logic [1:0] err_code;
  logic       cmd_overrun;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] cmd;
    logic [6:0] occ;
    int         hold;
    bit         err_pulse;
    bit         exp_start;
    logic [1:0] exp_pkt;
    logic [1:0] exp_err;
  } vec_t;

  typedef struct {
    bit         started;
    logic [1:0] pkt;
    logic [1:0] err;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[10];

  tx_command_sequencer #(.TIMEOUT_CYCLES(TIMEOUT), .TO_W(10)) dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .cmd_valid          (cmd_valid),
    .cmd                (cmd),
    .flush_req          (flush_req),
    .buffer_occupancy   (buffer_occupancy),
    .tx_transfer_active (tx_transfer_active),
    .tx_error           (tx_error),
    .tx_packet          (tx_packet),
    .tx_start           (tx_start),
    .clear              (clear),
    .busy               (busy),
    .done               (done),
    .cmd_clear          (cmd_clear),
    .err_code           (err_code),
    .cmd_overrun        (cmd_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_tx_packet"},   tx_packet,   0);
    checkOutput({tag, "_tx_start"},    tx_start,    0);
    checkOutput({tag, "_clear"},       clear,       0);
    checkOutput({tag, "_busy"},        busy,        0);
    checkOutput({tag, "_done"},        done,        0);
    checkOutput({tag, "_cmd_clear"},   cmd_clear,   0);
    checkOutput({tag, "_err_code"},    err_code,    0);
    checkOutput({tag, "_cmd_overrun"}, cmd_overrun, 0);
  endtask

  // Pops the oldest expected outcome and compares it with the DUT at done.
  task automatic scoreDone(input string tag, input bit started);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_scoreboard: actual=unexpected_done required=queued_entry", tag);
      return;
    end
    e = exp_q.pop_front();
    checkOutput({tag, "_started"},   started,   e.started);
    checkOutput({tag, "_pkt"},       tx_packet, e.pkt);
    checkOutput({tag, "_err"},       err_code,  e.err);
    checkOutput({tag, "_cmd_clear"}, cmd_clear, 1);
    checkOutput({tag, "_busy_done"}, busy,      1);
  endtask

  // Drives one command at the current negedge, plays the transmitter side,
  // and returns at the negedge after done with the DUT back in IDLE.
  task automatic applyStimulus(input vec_t v, input int idx);
    string tag;
    int    start_c;
    int    done_c;
    int    act_left;
    bit    started;
    exp_t  e;
    tag      = $sformatf("vec%0d", idx);
    start_c  = -1;
    done_c   = -1;
    act_left = 0;
    started  = 1'b0;
    e.started = v.exp_start;
    e.pkt     = v.exp_pkt;
    e.err     = v.exp_err;
    exp_q.push_back(e);
    cmd              = v.cmd;
    buffer_occupancy = v.occ;
    cmd_valid        = 1'b1;
    for (int c = 1; c <= TIMEOUT + 100 && done_c < 0; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      tx_error  = 1'b0;
      if (tx_start) begin
        started = 1'b1;
        start_c = c;
        checkOutput({tag, "_start_latency"}, c, 2);
        checkOutput({tag, "_pkt_at_start"}, tx_packet, v.exp_pkt);
        if (v.hold > 0) begin
          tx_transfer_active = 1'b1;
          act_left           = v.hold;
        end
      end else if (act_left > 0) begin
        act_left--;
        if (v.err_pulse && act_left == v.hold / 2) tx_error = 1'b1;
        if (act_left == 0) tx_transfer_active = 1'b0;
      end
      if (done) begin
        done_c = c;
        scoreDone(tag, started);
        if (!v.exp_start) begin
          checkOutput({tag, "_reject_latency"}, done_c, 2);
        end else if (v.hold == 0) begin
          checkOutput({tag, "_timeout_window"},
                      int'((done_c - start_c) >= TIMEOUT && (done_c - start_c) <= TIMEOUT + 4), 1);
        end else if (!v.err_pulse) begin
          checkOutput({tag, "_done_latency"}, done_c - start_c, v.hold + 1);
        end
      end
    end
    tx_transfer_active = 1'b0;
    tx_error           = 1'b0;
    if (done_c < 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_done_wait: actual=no_done required=done", tag);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    @(negedge clk);
    checkOutput({tag, "_busy_after"}, busy, 0);
    checkOutput({tag, "_done_after"}, done, 0);
  endtask

  initial begin
    int done_seen;
    int end_c;

    //            cmd     occ    hold err start pkt   err
    vecs[0] = '{8'd2,   7'd0,  5, 1'b0, 1'b1, 2'd0, 2'd0};
    vecs[1] = '{8'd1,   7'd0,  0, 1'b0, 1'b0, 2'd0, 2'd1};
    vecs[2] = '{8'd1,   7'd16, 3, 1'b0, 1'b1, 2'd2, 2'd0};
    vecs[3] = '{8'd4,   7'd0,  0, 1'b0, 1'b1, 2'd3, 2'd2};
    vecs[4] = '{8'd3,   7'd8,  6, 1'b1, 1'b1, 2'd1, 2'd3};
    vecs[5] = '{8'd4,   7'd9,  2, 1'b0, 1'b1, 2'd3, 2'd0};
    vecs[6] = '{8'd0,   7'd9,  0, 1'b0, 1'b0, 2'd0, 2'd1};
    vecs[7] = '{8'hFF,  7'd9,  0, 1'b0, 1'b0, 2'd0, 2'd1};
    vecs[8] = '{8'd5,   7'd9,  0, 1'b0, 1'b0, 2'd0, 2'd1};
    vecs[9] = '{8'd2,   7'd1,  2, 1'b0, 1'b1, 2'd0, 2'd0};

    n_rst              = 1'b1;
    cmd_valid          = 1'b0;
    cmd                = 8'd0;
    flush_req          = 1'b0;
    buffer_occupancy   = 7'd0;
    tx_transfer_active = 1'b0;
    tx_error           = 1'b0;

    repeat (3) @(negedge clk);
    checkAllZero("reset");
    n_rst = 1'b0;
    @(negedge clk);

    // Table records run back-to-back: each starts in the IDLE cycle right
    // after the previous REPORT.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Flush and command in the same IDLE cycle; err_code stays at vec9's 0.
    $display("[TB] flush/command collision");
    flush_req        = 1'b1;
    cmd_valid        = 1'b1;
    cmd              = 8'd2;
    buffer_occupancy = 7'd40;
    @(negedge clk);
    flush_req = 1'b0;
    cmd_valid = 1'b0;
    checkOutput("coll_clear",    clear,       1);
    checkOutput("coll_overrun",  cmd_overrun, 1);
    checkOutput("coll_busy",     busy,        1);
    checkOutput("coll_no_start", tx_start,    0);
    @(negedge clk);
    checkOutput("coll_clear_once", clear,       0);
    checkOutput("coll_overrun_1x", cmd_overrun, 0);
    checkOutput("coll_no_start2",  tx_start,    0);
    @(negedge clk);
    checkOutput("coll_busy_wait", busy, 1);
    buffer_occupancy = 7'd0;
    @(negedge clk);
    checkOutput("coll_busy_drop", busy,     0);
    checkOutput("coll_err_kept",  err_code, 0);
    checkOutput("coll_no_done",   done,     0);
    checkOutput("coll_no_start3", tx_start, 0);

    // Flush that never drains: times out back to IDLE with err_code=2.
    $display("[TB] flush timeout");
    flush_req        = 1'b1;
    buffer_occupancy = 7'd5;
    done_seen        = 0;
    end_c            = -1;
    for (int c = 1; c <= TIMEOUT + 100 && end_c < 0; c++) begin
      @(negedge clk);
      flush_req = 1'b0;
      if (done) done_seen++;
      if (!busy) end_c = c;
    end
    checkOutput("flto_window", int'(end_c >= TIMEOUT && end_c <= TIMEOUT + 6), 1);
    checkOutput("flto_err",    err_code,  2);
    checkOutput("flto_nodone", done_seen, 0);
    buffer_occupancy = 7'd0;

    // Overrun during WAIT_DONE, then a command in the REPORT cycle.
    $display("[TB] overrun while busy");
    exp_q.push_back('{1'b1, 2'd2, 2'd0});
    cmd              = 8'd1;
    buffer_occupancy = 7'd16;
    cmd_valid        = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("ovr_start", tx_start, 1);
    tx_transfer_active = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cmd       = 8'd3;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("ovr_pulse",    cmd_overrun, 1);
    checkOutput("ovr_pkt_kept", tx_packet,   2);
    checkOutput("ovr_busy",     busy,        1);
    checkOutput("ovr_no_start", tx_start,    0);
    @(negedge clk);
    checkOutput("ovr_pulse_1x", cmd_overrun, 0);
    tx_transfer_active = 1'b0;
    @(negedge clk);
    checkOutput("ovr_done", done, 1);
    scoreDone("ovr", 1'b1);
    cmd       = 8'd2;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("rpt_overrun", cmd_overrun, 1);
    checkOutput("rpt_idle",    busy,        0);
    @(negedge clk);
    checkOutput("rpt_dropped",  busy,     0);
    checkOutput("rpt_no_start", tx_start, 0);

    // Reset mid-WAIT_DONE: outputs clear at once and no done follows.
    $display("[TB] reset mid-transfer");
    cmd              = 8'd4;
    buffer_occupancy = 7'd0;
    cmd_valid        = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_start", tx_start, 1);
    tx_transfer_active = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_busy_pre", busy,      1);
    checkOutput("rst_pkt_pre",  tx_packet, 3);
    #2;
    n_rst = 1'b1;
    #1;
    checkAllZero("rst_async");
    done_seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    tx_transfer_active = 1'b0;
    n_rst              = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    checkOutput("rst_no_done", done_seen, 0);
    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
